// File: rtl/scrambler.sv
// Multiplicative (self-synchronising) scrambler: WS bits per word, MSB first, valid/ready on both sides.
// Optional macro SCRAMBLER_IDLE_FILL_EN inserts scrambled all-zero fill words whenever the input idles.
module scrambler #(
  parameter int            WS           = 7,
  parameter int            LN           = 31,
  parameter logic [LN-1:0] TAPS         = 31'h00_00_20_01,
  parameter logic [LN-1:0] INITIAL_FILL = {{(LN-1){1'b0}}, 1'b1}
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_sync,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [WS-1:0] i_word,
  output logic          o_valid,
  input  logic          i_ready,
`ifdef SCRAMBLER_IDLE_FILL_EN
  output logic          o_fill,
`endif
  output logic [WS-1:0] o_word
);

  // Scrambled bits are shifted back into the register so the state tracks what the far end receives.
  function automatic logic [LN+WS-1:0] scramble(input logic [WS-1:0] w, input logic [LN-1:0] s_in);
    logic [LN-1:0] s;
    logic [WS-1:0] o;
    logic          b;
    s = s_in;
    o = '0;
    for (int k = WS - 1; k >= 0; k--) begin
      b    = w[k] ^ (^(s & TAPS));
      o[k] = b;
      s    = {b, s[LN-1:1]};
    end
    return {s, o};
  endfunction

  logic [LN-1:0] sreg_q, sreg_d;
  logic [WS-1:0] word_q, word_d;
  logic          vld_q, vld_d;
  logic          ready;
  logic          accept;
  logic          take;
  logic [WS-1:0] in_word;
  logic [LN-1:0] sreg_nx;
  logic [WS-1:0] word_nx;
`ifdef SCRAMBLER_IDLE_FILL_EN
  logic          fill_q, fill_d;
`endif

  always_comb begin
    ready   = (!vld_q || i_ready) && !i_sync;
    accept  = i_valid && ready;
`ifdef SCRAMBLER_IDLE_FILL_EN
    take    = ready;
    in_word = i_valid ? i_word : '0;
`else
    take    = accept;
    in_word = i_word;
`endif
    {sreg_nx, word_nx} = scramble(in_word, sreg_q);
  end

  // Output slot update: resync outranks a new word, which outranks a plain drain.
  always_comb begin
    sreg_d = sreg_q;
    word_d = word_q;
    vld_d  = vld_q;
`ifdef SCRAMBLER_IDLE_FILL_EN
    fill_d = fill_q;
`endif
    if (i_sync) begin
      sreg_d = INITIAL_FILL;
      vld_d  = 1'b0;
    end else if (take) begin
      sreg_d = sreg_nx;
      word_d = word_nx;
      vld_d  = 1'b1;
`ifdef SCRAMBLER_IDLE_FILL_EN
      fill_d = !accept;
`endif
    end else if (vld_q && i_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sreg_q <= INITIAL_FILL;
      word_q <= '0;
      vld_q  <= 1'b0;
`ifdef SCRAMBLER_IDLE_FILL_EN
      fill_q <= 1'b0;
`endif
    end else begin
      sreg_q <= sreg_d;
      word_q <= word_d;
      vld_q  <= vld_d;
`ifdef SCRAMBLER_IDLE_FILL_EN
      fill_q <= fill_d;
`endif
    end
  end

  assign o_ready = ready;
  assign o_valid = vld_q;
  assign o_word  = word_q;
`ifdef SCRAMBLER_IDLE_FILL_EN
  assign o_fill  = fill_q;
`endif

endmodule

// File: doc/scrambler.md
Name: scrambler

Overview:
- Multiplicative (self-synchronising) scrambler: the transmit-side counterpart of the team's multiplicative descrambler.
- Scrambles WS bits per accepted word, MSB first, with a valid/ready stream handshake on both sides.
- Sits between the framer/bit source and the modulator.
- With identical WS, LN, TAPS and INITIAL_FILL, a descrambler fed o_word recovers i_word exactly.

Parameters:
- WS, 7, bits per word; bit WS-1 is first in time.
- LN, 31, LFSR length / polynomial degree.
- TAPS, 31'h00_00_20_01 (LN bits), feedback tap mask.
- INITIAL_FILL, {{(LN-1){1'b0}},1'b1} (LN bits), state after reset or resync.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active high.
- i_sync  in  1  synchronous resync: reload INITIAL_FILL, flush output register.
- i_valid  in  1  input word valid.
- o_ready  out  1  scrambler can accept a word this cycle.
- i_word  in  WS  plain input word.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts o_word.
- o_word  out  WS  scrambled word.

Behaviour:
- Reset (async assert, sync deassert): sreg=INITIAL_FILL, o_valid=0, o_word=0. o_ready is combinational, so it reads 1 during reset.
- o_ready = !o_valid || i_ready. Accept occurs when i_valid && o_ready.
- Bit recursion, processed for k = WS-1 down to 0 with s starting at sreg:
  - b = i_word[k] ^ ^(s & TAPS)
  - s = {b, s[LN-1:1]}
  - Shift in the SCRAMBLED bit b, so the state matches the descrambler's received-bit shift.
- On accept, on the next edge:
  - o_word <= {b(WS-1)..b(0)}, o_valid <= 1, sreg <= final s.
- Latency: one clock from accept to o_valid.
- Full throughput: one word per clock while i_ready is held high.
- Output hold: o_word and o_valid stay stable while o_valid && !i_ready. sreg does not advance unless a word is accepted.
- Output drain: when o_valid && i_ready and no accept, o_valid <= 0 and o_word keeps its last value.
- i_sync high: sreg <= INITIAL_FILL, o_valid <= 0. Any input offered that cycle is dropped, and o_ready is forced 0 that cycle. i_sync has priority over accept.
- A word cannot be dropped by backpressure. Input words are accepted only when the output slot is free or being emptied in the same cycle.
- Async reset mid-stream discards the pending output word immediately.

Optional Feature:
- Macro: SCRAMBLER_IDLE_FILL_EN.
- Defined:
  - When o_ready && !i_valid && !i_sync, the block internally accepts an all-zero word.
  - It scrambles that word, advances sreg, and presents it with o_valid=1.
  - Result: the line never idles, and the far-end descrambler stays synchronised.
  - Adds output o_fill (1 bit), registered alongside o_word, high for fill words; reset value 0.
- Undefined: no fill words, sreg advances only on real accepts, o_fill port absent.

Test Plan:
- Reset, then three i_word=7'h00 with i_ready=1 -> o_word 7'h40, 7'h00, 7'h04 on consecutive cycles, each 1 clock after its accept.
- Hold i_ready=0 after the first 7'h00 is accepted -> o_valid=1 with o_word=7'h40 held and o_ready=0. Release i_ready -> the next word 7'h00 yields 7'h00 (sreg did not advance while stalled).
- 1000 random words, random i_valid/i_ready, looped into a descrambler with the same parameters -> descrambler output equals the input sequence, no drops or duplicates.
- Pulse i_sync after 5 words, then send 7'h00 x3 -> 7'h40, 7'h00, 7'h04 again; the word offered during the i_sync cycle is not accepted.
- Assert i_reset asynchronously mid-stream with o_valid=1 -> o_valid=0 and o_word=0 before the next edge; sequence restarts at 7'h40.
- With SCRAMBLER_IDLE_FILL_EN, i_valid=0, i_ready=1 after reset -> o_word 7'h40, 7'h00, 7'h04 with o_fill=1. Without the macro -> o_valid stays 0.
